// File: rtl/spi_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// spi_cmd_ctrl
// Turns a byte stream from an SPI slave into register-bus transactions.
// The first byte of a frame is a command: bit 7 selects write (1) or read
// (0), bits 6:0 the start address. Writes take one data byte per bus write;
// reads return data through the SPI slave, one bus read per dummy byte.
// Bursts step the address by AUTO_INC (7-bit wrap).
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cs_i                  raw SPI chip select (active-low, asynchronous)
//   rx_dv_i, rx_byte_i    received-byte strobe and data from the SPI slave
//   tx_dv_o, tx_byte_o    load strobe and next MISO byte to the SPI slave
//   bus_req_o/bus_gnt_i   register-bus request/grant handshake
//   bus_rvalid_i          bus response (reads and writes)
//   bus_we_o, bus_addr_o, bus_wdata_o, bus_rdata_i   bus command and data
//   busy_o                FSM is not IDLE
//   overrun_o             sticky: a received byte was dropped this frame
// ---------------------------------------------------------------------------
module spi_cmd_ctrl #(
    parameter int         AUTO_INC    = 1,
    parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cs_i,
    input  logic       rx_dv_i,
    input  logic [7:0] rx_byte_i,
    output logic       tx_dv_o,
    output logic [7:0] tx_byte_o,
    output logic       bus_req_o,
    input  logic       bus_gnt_i,
    input  logic       bus_rvalid_i,
    output logic       bus_we_o,
    output logic [6:0] bus_addr_o,
    output logic [7:0] bus_wdata_o,
    input  logic [7:0] bus_rdata_i,
    output logic       busy_o,
    output logic       overrun_o
);

    localparam logic [6:0] ADDR_INC = 7'(AUTO_INC);

    typedef enum logic [2:0] {
        IDLE, CMD, WDATA, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, RD_NEXT
    } state_t;

    state_t     r_state;
    logic       r_cs_meta;
    logic       r_cs_s;
    logic [6:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_tx_byte;
    logic       r_bus_req;
    logic       r_bus_we;
    logic       r_overrun;
    // Chip select went high during a bus transaction: finish it, then idle.
    logic       r_abort;

    logic       w_frame_start;
    logic       w_rd_done;

    // tx_dv_o has to coincide with the cycle that starts the frame or sees
    // the read response, so both strobes are decoded from the current state
    // and inputs; tx_byte_o presents the new byte in that same cycle and the
    // register keeps it afterwards.
    assign w_frame_start = (r_state == IDLE) && !r_cs_s;
    assign w_rd_done     = (r_state == RD_WAIT) && bus_rvalid_i && !(r_abort || r_cs_s);

    assign tx_dv_o     = w_frame_start || w_rd_done;
    assign tx_byte_o   = w_frame_start ? STATUS_BYTE :
                         w_rd_done     ? bus_rdata_i : r_tx_byte;
    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_addr_o  = r_addr;
    assign bus_wdata_o = r_wdata;
    assign busy_o      = (r_state != IDLE);
    assign overrun_o   = r_overrun;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cs_meta <= 1'b1;
            r_cs_s    <= 1'b1;
            r_addr    <= 7'h00;
            r_wdata   <= 8'h00;
            r_tx_byte <= 8'h00;
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_overrun <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_cs_meta <= cs_i;
            r_cs_s    <= r_cs_meta;

            case (r_state)
                IDLE: begin
                    r_abort <= 1'b0;
                    if (!r_cs_s) begin
                        r_state   <= CMD;
                        r_tx_byte <= STATUS_BYTE;
                        r_overrun <= 1'b0;
                    end
                end

                // Chip-select release takes priority over a coincident byte.
                CMD: begin
                    if (r_cs_s) begin
                        r_state <= IDLE;
                    end else if (rx_dv_i) begin
                        r_addr <= rx_byte_i[6:0];
                        if (rx_byte_i[7]) begin
                            r_state <= WDATA;
                        end else begin
                            r_state   <= RD_REQ;
                            r_bus_req <= 1'b1;
                            r_bus_we  <= 1'b0;
                        end
                    end
                end

                WDATA: begin
                    if (r_cs_s) begin
                        r_state <= IDLE;
                    end else if (rx_dv_i) begin
                        r_wdata   <= rx_byte_i;
                        r_state   <= WR_REQ;
                        r_bus_req <= 1'b1;
                        r_bus_we  <= 1'b1;
                    end
                end

                // Bus phases: incoming bytes cannot be taken and are dropped.
                WR_REQ, RD_REQ: begin
                    if (rx_dv_i) r_overrun <= 1'b1;
                    if (r_cs_s)  r_abort   <= 1'b1;
                    if (bus_gnt_i) begin
                        r_bus_req <= 1'b0;
                        r_state   <= (r_state == WR_REQ) ? WR_WAIT : RD_WAIT;
                    end
                end

                WR_WAIT: begin
                    if (rx_dv_i) r_overrun <= 1'b1;
                    if (r_cs_s)  r_abort   <= 1'b1;
                    if (bus_rvalid_i) begin
                        r_addr  <= r_addr + ADDR_INC;
                        r_state <= (r_abort || r_cs_s) ? IDLE : WDATA;
                    end
                end

                RD_WAIT: begin
                    if (rx_dv_i) r_overrun <= 1'b1;
                    if (r_cs_s)  r_abort   <= 1'b1;
                    if (bus_rvalid_i) begin
                        if (r_abort || r_cs_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_tx_byte <= bus_rdata_i;
                            r_state   <= RD_NEXT;
                        end
                    end
                end

                // The dummy byte that shifted out the read data starts the
                // next read of the burst; its value is irrelevant.
                RD_NEXT: begin
                    if (r_cs_s) begin
                        r_state <= IDLE;
                    end else if (rx_dv_i) begin
                        r_addr    <= r_addr + ADDR_INC;
                        r_state   <= RD_REQ;
                        r_bus_req <= 1'b1;
                        r_bus_we  <= 1'b0;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_ctrl
// Cycle table for a single write frame followed by a read burst, then
// hand-written sequences for address wrap, overrun, cs abort and reset.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 2 time units after the edge.
// ---------------------------------------------------------------------------
module tb_spi_cmd_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cs_i;
    logic       rx_dv_i;
    logic [7:0] rx_byte_i;
    logic       tx_dv_o;
    logic [7:0] tx_byte_o;
    logic       bus_req_o;
    logic       bus_gnt_i;
    logic       bus_rvalid_i;
    logic       bus_we_o;
    logic [6:0] bus_addr_o;
    logic [7:0] bus_wdata_o;
    logic [7:0] bus_rdata_i;
    logic       busy_o;
    logic       overrun_o;

    always #5 clk_i = ~clk_i;

    spi_cmd_ctrl #(.AUTO_INC(1), .STATUS_BYTE(8'hA5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cs_i        (cs_i),
        .rx_dv_i     (rx_dv_i),
        .rx_byte_i   (rx_byte_i),
        .tx_dv_o     (tx_dv_o),
        .tx_byte_o   (tx_byte_o),
        .bus_req_o   (bus_req_o),
        .bus_gnt_i   (bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic       cs;
        logic       dv;
        logic [7:0] rxb;
        logic       gnt;
        logic       rv;
        logic [7:0] rdata;
        logic       e_txdv;
        logic [7:0] e_txb;
        logic       e_req;
        logic       e_we;
        logic [6:0] e_addr;
        logic [7:0] e_wdata;
        logic       e_busy;
        logic       e_ovr;
    } vec_t;

    localparam int NVEC = 28;
    vec_t tbl[NVEC];

    function automatic vec_t mk(
        input logic cs, input logic dv, input logic [7:0] rxb, input logic gnt,
        input logic rv, input logic [7:0] rdata, input logic e_txdv,
        input logic [7:0] e_txb, input logic e_req, input logic e_we,
        input logic [6:0] e_addr, input logic [7:0] e_wdata,
        input logic e_busy, input logic e_ovr);
        vec_t v;
        v.cs = cs; v.dv = dv; v.rxb = rxb; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_txdv = e_txdv; v.e_txb = e_txb; v.e_req = e_req; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_busy = e_busy; v.e_ovr = e_ovr;
        return v;
    endfunction

    // Drop cs and wait for the IDLE->CMD strobe carrying the status byte.
    task automatic start_frame(input string tag);
        logic got;
        got  = 1'b0;
        cs_i = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            if (tx_dv_o) begin
                got = 1'b1;
                chk({tag, " status byte"}, tx_byte_o, 8'hA5);
            end
            @(posedge clk_i);
            #1;
        end
        chk({tag, " frame start strobe"}, 8'(got), 8'd1);
        chk({tag, " busy after start"}, 8'(busy_o), 8'd1);
        chk({tag, " overrun cleared"}, 8'(overrun_o), 8'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv_i   = 1'b1;
        rx_byte_i = b;
        cyc();
        rx_dv_i   = 1'b0;
        rx_byte_i = 8'h00;
    endtask

    // Act as the bus slave for one transaction and check what is presented.
    task automatic serve(input string tag, input logic we, input logic [6:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata,
                         input int delay, input logic exp_tx);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus_req_o) seen = 1'b1;
            else cyc();
        end
        chk({tag, " request seen"}, 8'(seen), 8'd1);
        chk({tag, " we"}, 8'(bus_we_o), 8'(we));
        chk({tag, " addr"}, 8'(bus_addr_o), 8'(addr));
        if (we) chk({tag, " wdata"}, bus_wdata_o, wdata);
        for (int i = 0; i < delay; i++) begin
            cyc();
            chk({tag, " req held"}, 8'(bus_req_o), 8'd1);
        end
        bus_gnt_i = 1'b1;
        cyc();
        bus_gnt_i = 1'b0;
        chk({tag, " req dropped after grant"}, 8'(bus_req_o), 8'd0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rdata;
        #1;
        chk({tag, " tx_dv at rvalid"}, 8'(tx_dv_o), 8'(exp_tx));
        if (exp_tx) chk({tag, " tx_byte at rvalid"}, tx_byte_o, rdata);
        cyc();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 8'h00;
    endtask

    task automatic end_frame(input string tag);
        cs_i = 1'b1;
        for (int i = 0; i < 10 && busy_o; i++) cyc();
        chk({tag, " idle after cs high"}, 8'(busy_o), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Single write (addr 05, data 3C, grant after 2 cycles) then a read
        // burst at 10/11 returning AA/BB.
        //                cs dv rxb   g  rv rdat  txdv txb  req we addr   wdata busy ovr
        tbl[0]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0);
        tbl[1]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 7'h00, 8'h00, 0, 0);
        tbl[2]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0, 0, 7'h00, 8'h00, 0, 0);
        tbl[3]  = mk(0, 1, 8'h85, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 7'h00, 8'h00, 1, 0);
        tbl[4]  = mk(0, 1, 8'h3C, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 7'h05, 8'h00, 1, 0);
        tbl[5]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 1, 1, 7'h05, 8'h3C, 1, 0);
        tbl[6]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 1, 1, 7'h05, 8'h3C, 1, 0);
        tbl[7]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 8'hA5, 1, 1, 7'h05, 8'h3C, 1, 0);
        tbl[8]  = mk(0, 0, 8'h00, 0, 1, 8'h00, 0, 8'hA5, 0, 1, 7'h05, 8'h3C, 1, 0);
        tbl[9]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 7'h06, 8'h3C, 1, 0);
        tbl[10] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 7'h06, 8'h3C, 1, 0);
        tbl[11] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 7'h06, 8'h3C, 1, 0);
        tbl[12] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 7'h06, 8'h3C, 0, 0);
        tbl[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 7'h06, 8'h3C, 0, 0);
        tbl[14] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 7'h06, 8'h3C, 0, 0);
        tbl[15] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'hA5, 0, 1, 7'h06, 8'h3C, 0, 0);
        tbl[16] = mk(0, 1, 8'h10, 0, 0, 8'h00, 0, 8'hA5, 0, 1, 7'h06, 8'h3C, 1, 0);
        tbl[17] = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 8'hA5, 1, 0, 7'h10, 8'h3C, 1, 0);
        tbl[18] = mk(0, 0, 8'h00, 0, 1, 8'hAA, 1, 8'hAA, 0, 0, 7'h10, 8'h3C, 1, 0);
        tbl[19] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'hAA, 0, 0, 7'h10, 8'h3C, 1, 0);
        tbl[20] = mk(0, 1, 8'h00, 0, 0, 8'h00, 0, 8'hAA, 0, 0, 7'h10, 8'h3C, 1, 0);
        tbl[21] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'hAA, 1, 0, 7'h11, 8'h3C, 1, 0);
        tbl[22] = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 8'hAA, 1, 0, 7'h11, 8'h3C, 1, 0);
        tbl[23] = mk(0, 0, 8'h00, 0, 1, 8'hBB, 1, 8'hBB, 0, 0, 7'h11, 8'h3C, 1, 0);
        tbl[24] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'hBB, 0, 0, 7'h11, 8'h3C, 1, 0);
        tbl[25] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'hBB, 0, 0, 7'h11, 8'h3C, 1, 0);
        tbl[26] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'hBB, 0, 0, 7'h11, 8'h3C, 1, 0);
        tbl[27] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'hBB, 0, 0, 7'h11, 8'h3C, 0, 0);

        rst_i = 1'b1; cs_i = 1'b1; rx_dv_i = 1'b0; rx_byte_i = 8'h00;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 8'h00;
        cyc();
        cyc();
        rst_i = 1'b0;
        #1;
        chk("reset tx_dv", 8'(tx_dv_o), 8'd0);
        chk("reset tx_byte", tx_byte_o, 8'h00);
        chk("reset bus_req", 8'(bus_req_o), 8'd0);
        chk("reset bus_we", 8'(bus_we_o), 8'd0);
        chk("reset addr", 8'(bus_addr_o), 8'h00);
        chk("reset wdata", bus_wdata_o, 8'h00);
        chk("reset busy", 8'(busy_o), 8'd0);
        chk("reset overrun", 8'(overrun_o), 8'd0);
        cyc();

        for (int i = 0; i < NVEC; i++) begin
            cs_i = tbl[i].cs; rx_dv_i = tbl[i].dv; rx_byte_i = tbl[i].rxb;
            bus_gnt_i = tbl[i].gnt; bus_rvalid_i = tbl[i].rv; bus_rdata_i = tbl[i].rdata;
            #1;
            chk($sformatf("row%0d tx_dv", i), 8'(tx_dv_o), 8'(tbl[i].e_txdv));
            chk($sformatf("row%0d tx_byte", i), tx_byte_o, tbl[i].e_txb);
            chk($sformatf("row%0d bus_req", i), 8'(bus_req_o), 8'(tbl[i].e_req));
            chk($sformatf("row%0d bus_we", i), 8'(bus_we_o), 8'(tbl[i].e_we));
            chk($sformatf("row%0d addr", i), 8'(bus_addr_o), 8'(tbl[i].e_addr));
            chk($sformatf("row%0d wdata", i), bus_wdata_o, tbl[i].e_wdata);
            chk($sformatf("row%0d busy", i), 8'(busy_o), 8'(tbl[i].e_busy));
            chk($sformatf("row%0d overrun", i), 8'(overrun_o), 8'(tbl[i].e_ovr));
            @(posedge clk_i);
            #1;
        end
        cs_i = 1'b1; rx_dv_i = 1'b0; rx_byte_i = 8'h00;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 8'h00;
        cyc();

        // Address wrap: write burst starting at 7F continues at 00.
        start_frame("wrap");
        send_byte(8'hFF);
        send_byte(8'h01);
        serve("wrap w0", 1'b1, 7'h7F, 8'h01, 8'h00, 1, 1'b0);
        chk("wrap addr after 7F", 8'(bus_addr_o), 8'h00);
        send_byte(8'h02);
        serve("wrap w1", 1'b1, 7'h00, 8'h02, 8'h00, 0, 1'b0);
        end_frame("wrap");

        // Overrun: a byte arriving in WR_WAIT is dropped and flagged.
        start_frame("ovr");
        send_byte(8'h81);
        send_byte(8'h55);
        chk("ovr in WR_REQ", 8'(bus_req_o), 8'd1);
        bus_gnt_i = 1'b1;
        cyc();
        bus_gnt_i = 1'b0;
        send_byte(8'h77);
        chk("ovr flag set", 8'(overrun_o), 8'd1);
        chk("ovr state kept busy", 8'(busy_o), 8'd1);
        chk("ovr no new request", 8'(bus_req_o), 8'd0);
        chk("ovr wdata kept", bus_wdata_o, 8'h55);
        bus_rvalid_i = 1'b1;
        cyc();
        bus_rvalid_i = 1'b0;
        chk("ovr addr incremented", 8'(bus_addr_o), 8'h02);
        cyc();
        chk("ovr dropped byte not written", 8'(bus_req_o), 8'd0);
        end_frame("ovr");
        chk("ovr sticky in idle", 8'(overrun_o), 8'd1);
        start_frame("ovr next");
        end_frame("ovr next");

        // cs abort while a read request waits 5 cycles for its grant.
        start_frame("abort");
        send_byte(8'h20);
        chk("abort req", 8'(bus_req_o), 8'd1);
        chk("abort we", 8'(bus_we_o), 8'd0);
        chk("abort addr", 8'(bus_addr_o), 8'h20);
        cs_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("abort req held %0d", i), 8'(bus_req_o), 8'd1);
            chk($sformatf("abort no tx_dv %0d", i), 8'(tx_dv_o), 8'd0);
        end
        bus_gnt_i = 1'b1;
        cyc();
        bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 8'hCC;
        #1;
        chk("abort tx_dv suppressed", 8'(tx_dv_o), 8'd0);
        chk("abort tx_byte unchanged", tx_byte_o, 8'hA5);
        cyc();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 8'h00;
        chk("abort idle", 8'(busy_o), 8'd0);
        chk("abort req low", 8'(bus_req_o), 8'd0);

        // Reset in WR_REQ aborts the request at once.
        start_frame("rst");
        send_byte(8'h90);
        send_byte(8'h11);
        chk("rst pre req", 8'(bus_req_o), 8'd1);
        chk("rst pre we", 8'(bus_we_o), 8'd1);
        rst_i = 1'b1;
        cs_i  = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("rst req", 8'(bus_req_o), 8'd0);
        chk("rst busy", 8'(busy_o), 8'd0);
        chk("rst we", 8'(bus_we_o), 8'd0);
        chk("rst addr", 8'(bus_addr_o), 8'h00);
        chk("rst wdata", bus_wdata_o, 8'h00);
        chk("rst tx_byte", tx_byte_o, 8'h00);
        chk("rst tx_dv", 8'(tx_dv_o), 8'd0);
        cyc();
        chk("rst stays idle", 8'(busy_o), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
